twos_complement_seq: RTL



---
 rtl/twos_complement_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/twos_complement_seq.sv
// Multi-cycle two's-complement conversion unit: -A, -B, |A| and sign-magnitude A to
// two's complement, rippling the +1 carry CHUNK bits per cycle. Optional macro:
// TWOS_COMPLEMENT_EARLY_DONE_EN finishes as soon as the carry dies out.
module twos_complement_seq #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             result_valid,
    input  logic             result_ready
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned M    = WIDTH - 1;

    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  w_q, w_d;
    logic              c_q, c_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              ovf_q, ovf_d;

    logic [CHUNK-1:0]  chunk;
    logic [CHUNK:0]    sum;
    logic              last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    // Current chunk selected by constant-index loop so the mux stays lint-clean.
    always_comb begin
        chunk = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (idx_q == IDXW'(k)) begin
                chunk = w_q[k*CHUNK +: CHUNK];
            end
        end
        sum  = {1'b0, chunk} + {{CHUNK{1'b0}}, c_q};
        last = (idx_q == LAST_IDX);
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        c_d     = c_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    state_d = BUSY;
                    idx_d   = '0;
                    case (mode)
                        2'b00: begin
                            w_d   = ~a_in;
                            c_d   = 1'b1;
                            ovf_d = (a_in == MOST_NEG);
                        end
                        2'b01: begin
                            w_d   = ~b_in;
                            c_d   = 1'b1;
                            ovf_d = (b_in == MOST_NEG);
                        end
                        2'b10: begin
                            if (a_in[M]) begin
                                w_d   = ~a_in;
                                c_d   = 1'b1;
                                ovf_d = (a_in == MOST_NEG);
                            end else begin
                                w_d   = a_in;
                                c_d   = 1'b0;
                                ovf_d = 1'b0;
                            end
                        end
                        default: begin
                            // Clearing the sign bit before inverting maps -0 onto 0.
                            if (a_in[M]) begin
                                w_d = ~{1'b0, a_in[M-1:0]};
                                c_d = 1'b1;
                            end else begin
                                w_d = a_in;
                                c_d = 1'b0;
                            end
                            ovf_d = 1'b0;
                        end
                    endcase
                end
            end

            BUSY: begin
`ifdef TWOS_COMPLEMENT_EARLY_DONE_EN
                if (!c_q) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    for (int unsigned k = 0; k < N; k++) begin
                        if (idx_q == IDXW'(k)) begin
                            w_d[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
                        end
                    end
                    c_d   = sum[CHUNK];
                    idx_d = idx_q + 1'b1;
                    if (!sum[CHUNK] || last) begin
                        state_d = DONE;
                        idx_d   = '0;
                        c_d     = 1'b0;
                    end
                end
`else
                for (int unsigned k = 0; k < N; k++) begin
                    if (idx_q == IDXW'(k)) begin
                        w_d[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
                    end
                end
                c_d   = sum[CHUNK];
                idx_d = idx_q + 1'b1;
                if (last) begin
                    // Carry out of the MSB chunk is dropped.
                    state_d = DONE;
                    idx_d   = '0;
                    c_d     = 1'b0;
                end
`endif
            end

            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                    w_d     = '0;
                    ovf_d   = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                w_d     = '0;
                c_d     = 1'b0;
                idx_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    assign start_ready  = (state_q == IDLE);
    assign result_valid = (state_q == DONE);
    assign result       = (state_q == DONE) ? w_q : '0;
    assign overflow     = (state_q == DONE) ? ovf_q : 1'b0;

endmodule
